// File: rtl/fib_check.sv
// fib_check: receive-side checker for a Fibonacci term stream.
// Captures the first two accepted terms as seeds and checks each later term
// against the sum of the previous two.
// Optional feature macro: FIB_CHECK_WRAP_EN. When defined, sums wrap modulo
// 2^WIDTH. When undefined, a carry out of the sum is reported as an overflow.
module fib_check #(
   parameter int unsigned WIDTH   = 6,
   parameter int unsigned MAX_LEN = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           in_valid,
   input  logic [WIDTH-1:0]               in_data,
   output logic                           in_ready,
   output logic                           busy,
   output logic                           pass,
   output logic                           fail,
   output logic                           ovf,
   output logic [$clog2(MAX_LEN)-1:0]     err_idx,
   output logic [$clog2(MAX_LEN+1)-1:0]   count,
   output logic [WIDTH-1:0]               seed0,
   output logic [WIDTH-1:0]               seed1
);

   localparam int unsigned IW = $clog2(MAX_LEN);
   localparam int unsigned CW = $clog2(MAX_LEN + 1);
   localparam logic [CW-1:0] LAST = CW'(MAX_LEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEED0,
      S_SEED1,
      S_CHECK,
      S_DONE,
      S_FAIL
   } state_t;

   state_t            state, state_n;
   logic [WIDTH-1:0]  r0, r1, r0_n, r1_n;
   logic [WIDTH-1:0]  seed0_n, seed1_n;
   logic              ovf_n;
   logic [IW-1:0]     err_idx_n;
   logic [CW-1:0]     count_n, count_inc;
   logic              xfer;
   logic              carry;
   logic [WIDTH-1:0]  exp_lo;

`ifdef FIB_CHECK_WRAP_EN
   // Truncating generator: only the low bits of the sum are meaningful.
   always_comb begin
      exp_lo = r0 + r1;
      carry  = 1'b0;
   end
`else
   logic [WIDTH:0]    exp_full;

   // Full-width sum so a carry out can be flagged as overflow.
   always_comb begin
      exp_full = {1'b0, r0} + {1'b0, r1};
      exp_lo   = exp_full[WIDTH-1:0];
      carry    = exp_full[WIDTH];
   end
`endif

   // Handshake and status decode; start blocks any beat in its cycle.
   always_comb begin
      busy     = (state == S_SEED0) || (state == S_SEED1) || (state == S_CHECK);
      in_ready = busy && !start;
      xfer     = in_valid && in_ready;
      pass     = (state == S_DONE);
      fail     = (state == S_FAIL);
   end

   // Next-state and datapath update.
   always_comb begin
      state_n   = state;
      r0_n      = r0;
      r1_n      = r1;
      seed0_n   = seed0;
      seed1_n   = seed1;
      ovf_n     = ovf;
      err_idx_n = err_idx;
      count_inc = count + 1'b1;
      count_n   = count;

      if (start) begin
         state_n   = S_SEED0;
         r0_n      = '0;
         r1_n      = '0;
         seed0_n   = '0;
         seed1_n   = '0;
         ovf_n     = 1'b0;
         err_idx_n = '0;
         count_n   = '0;
      end else begin
         unique case (state)
            S_SEED0: begin
               if (xfer) begin
                  seed0_n = in_data;
                  r0_n    = in_data;
                  count_n = count_inc;
                  state_n = S_SEED1;
               end
            end
            S_SEED1: begin
               if (xfer) begin
                  seed1_n = in_data;
                  r1_n    = in_data;
                  count_n = count_inc;
                  state_n = S_CHECK;
               end
            end
            S_CHECK: begin
               if (xfer) begin
                  count_n = count_inc;
                  r0_n    = r1;
                  r1_n    = in_data;
                  if (carry) begin
                     state_n   = S_FAIL;
                     ovf_n     = 1'b1;
                     err_idx_n = count[IW-1:0];
                  end else if (exp_lo != in_data) begin
                     state_n   = S_FAIL;
                     ovf_n     = 1'b0;
                     err_idx_n = count[IW-1:0];
                  end else if (count_inc == LAST) begin
                     state_n   = S_DONE;
                  end
               end
            end
            default: begin
               state_n = state;
            end
         endcase
      end
   end

   // State and datapath registers; reset has priority over start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         r0      <= '0;
         r1      <= '0;
         seed0   <= '0;
         seed1   <= '0;
         ovf     <= 1'b0;
         err_idx <= '0;
         count   <= '0;
      end else begin
         state   <= state_n;
         r0      <= r0_n;
         r1      <= r1_n;
         seed0   <= seed0_n;
         seed1   <= seed1_n;
         ovf     <= ovf_n;
         err_idx <= err_idx_n;
         count   <= count_n;
      end
   end

endmodule

// File: tb/tb_fib_check.sv
// tb_fib_check: directed bench for fib_check with a 32-term instance and a
// 4-term instance for the completion case.
module tb_fib_check;

   logic       clk = 1'b0;
   logic       rst, start, in_valid;
   logic [5:0] in_data;
   logic       in_ready, busy, pass, fail, ovf;
   logic [4:0] err_idx;
   logic [5:0] count;
   logic [5:0] seed0, seed1;

   logic       start4, in_valid4;
   logic [5:0] in_data4;
   logic       in_ready4, busy4, pass4, fail4, ovf4;
   logic [1:0] err_idx4;
   logic [2:0] count4;
   logic [5:0] seed0_4, seed1_4;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   fib_check #(.WIDTH(6), .MAX_LEN(32)) u_dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready), .busy(busy), .pass(pass),
      .fail(fail), .ovf(ovf), .err_idx(err_idx), .count(count),
      .seed0(seed0), .seed1(seed1)
   );

   fib_check #(.WIDTH(6), .MAX_LEN(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .in_valid(in_valid4),
      .in_data(in_data4), .in_ready(in_ready4), .busy(busy4), .pass(pass4),
      .fail(fail4), .ovf(ovf4), .err_idx(err_idx4), .count(count4),
      .seed0(seed0_4), .seed1(seed1_4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one beat to the 32-term checker; it must be accepted this cycle.
   task automatic send(input int d);
      in_valid = 1'b1;
      in_data  = d[5:0];
      #1;
      check("in_ready_beat", in_ready, 1);
      tick();
   endtask

   task automatic send4(input int d);
      in_valid4 = 1'b1;
      in_data4  = d[5:0];
      #1;
      check("in_ready4_beat", in_ready4, 1);
      tick();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      #1;
      check("in_ready_during_start", in_ready, 0);
      tick();
      start = 1'b0;
   endtask

   int good [10] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55};

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
      start4 = 1'b0; in_valid4 = 1'b0; in_data4 = '0;
      repeat (2) tick();

      // Reset state
      check("rst_busy", busy, 0);
      check("rst_pass", pass, 0);
      check("rst_fail", fail, 0);
      check("rst_ovf", ovf, 0);
      check("rst_err_idx", err_idx, 0);
      check("rst_count", count, 0);
      check("rst_seed0", seed0, 0);
      check("rst_seed1", seed1, 0);
      check("rst_in_ready", in_ready, 0);

      // Idle ignores beats without start
      rst = 1'b0;
      in_valid = 1'b1; in_data = 6'd5;
      #1;
      check("idle_in_ready", in_ready, 0);
      tick();
      check("idle_count", count, 0);
      in_valid = 1'b0;

      // Good sequence
      pulse_start();
      check("start_busy", busy, 1);
      check("start_count", count, 0);
      for (int i = 0; i < 10; i++) send(good[i]);
      check("good_count", count, 10);
      check("good_fail", fail, 0);
      check("good_seed0", seed0, 1);
      check("good_seed1", seed1, 1);
      check("good_busy", busy, 1);
      check("good_pass", pass, 0);

      // Wrap: 34 + 55 = 89, 89 mod 64 = 25
      send(25);
`ifdef FIB_CHECK_WRAP_EN
      check("wrap_count", count, 11);
      check("wrap_fail", fail, 0);
      check("wrap_busy", busy, 1);
`else
      check("ovf_fail", fail, 1);
      check("ovf_ovf", ovf, 1);
      check("ovf_err_idx", err_idx, 10);
      check("ovf_count", count, 11);
      check("ovf_busy", busy, 0);
      check("ovf_in_ready", in_ready, 0);
`endif
      in_valid = 1'b0;

      // Mismatch: 1,1,2,4
      pulse_start();
      check("restart_fail", fail, 0);
      check("restart_ovf", ovf, 0);
      check("restart_count", count, 0);
      send(1); send(1); send(2); send(4);
      in_data = 6'd7;
      check("mis_fail", fail, 1);
      check("mis_ovf", ovf, 0);
      check("mis_err_idx", err_idx, 3);
      check("mis_count", count, 4);
      check("mis_in_ready", in_ready, 0);
      tick();
      check("mis_extra_count", count, 4);
      check("mis_sticky", fail, 1);
      in_valid = 1'b0;

      // Completion on the 4-term instance: 0,1,1,2
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      send4(0); send4(1); send4(1); send4(2);
      check("done_pass", pass4, 1);
      check("done_busy", busy4, 0);
      check("done_count", count4, 4);
      check("done_in_ready", in_ready4, 0);
      check("done_fail", fail4, 0);
      check("done_seed1", seed1_4, 1);
      in_valid4 = 1'b0;

      // Restart mid-sequence, start wins over a coincident beat
      pulse_start();
      send(3); send(4);
      check("pre_restart_count", count, 2);
      start = 1'b1; in_valid = 1'b1; in_data = 6'd9;
      #1;
      check("restart_beat_ready", in_ready, 0);
      tick();
      start = 1'b0;
      check("restart_count0", count, 0);
      check("restart_seed0", seed0, 0);
      check("restart_busy", busy, 1);
      #1;
      check("restart_ready_seed0", in_ready, 1);
      send(2); send(3); send(5);
      check("restart2_seed0", seed0, 2);
      check("restart2_seed1", seed1, 3);
      check("restart2_count", count, 3);
      check("restart2_fail", fail, 0);

      // Reset mid-sequence discards progress
      rst = 1'b1;
      tick();
      check("mid_rst_count", count, 0);
      check("mid_rst_seed0", seed0, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_in_ready", in_ready, 0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("post_rst_in_ready", in_ready, 0);
         tick();
      end
      check("post_rst_count", count, 0);

      // rst and start together: reset wins
      rst = 1'b1; start = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0;
      check("rst_start_busy", busy, 0);
      check("rst_start_in_ready", in_ready, 0);
      in_valid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
